// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // One in-flight destination tracked per downstream stage.
  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] rd;
    logic             wb;
    logic             ld;
  } sb_entry_t;

  // A source depends on an entry when it reads a non-zero register the entry will write.
  function automatic logic sb_hit(input sb_entry_t e, input logic [REG_W-1:0] s,
                                  input logic use_s);
    return e.vld & e.wb & (e.rd == s) & (s != '0) & use_s;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-source dependency evaluation: forward select and stall request.
// HAZARD_CTRL_PERF_EN adds the load-use indication used by the perf counters.
module hazard_match
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] i_src,
  input  logic             i_use,
  input  logic             i_is_bj,
  input  sb_entry_t        i_ex,
  input  sb_entry_t        i_mem,
  input  sb_entry_t        i_wb,
  output logic [1:0]       o_fwd_sel,
  output logic             o_stall
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic             o_loaduse
`endif
);

  logic hit_ex;
  logic hit_mem;
  logic hit_wb;

  assign hit_ex  = sb_hit(i_ex, i_src, i_use);
  assign hit_mem = sb_hit(i_mem, i_src, i_use);
  assign hit_wb  = sb_hit(i_wb, i_src, i_use);

  // Branches/jumps need their operands in ID; loads are not ready until after MEM.
  always_comb begin
    o_stall = (hit_ex & (i_is_bj | i_ex.ld)) | (hit_mem & i_mem.ld & i_is_bj);
  end

  // Youngest producer wins; a load in MEM is left to EX-stage forwarding.
  always_comb begin
    o_fwd_sel = FWD_RF;
    if (hit_mem) begin
      o_fwd_sel = i_mem.ld ? FWD_RF : FWD_EXMEM;
    end else if (hit_wb) begin
      o_fwd_sel = FWD_WB;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  assign o_loaduse = hit_ex & i_ex.ld;
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core with branch resolution in ID.
// Optional performance counters are enabled with the HAZARD_CTRL_PERF_EN macro.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned WDT_MAX = 15
`ifdef HAZARD_CTRL_PERF_EN
  ,
  parameter int unsigned PERF_W  = 32
`endif
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic [REG_W-1:0] i_id_rd,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_id_is_branch,
  input  logic             i_id_is_jump,
  input  logic             i_id_wb_en,
  input  logic             i_id_mem_read,
  input  logic             i_redirect_valid,
  input  logic             i_mem_stall,
  output logic [1:0]       o_forward_a_sel,
  output logic [1:0]       o_forward_b_sel,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_flush_if_id,
  output logic             o_flush_id_ex,
  output logic             o_stall_timeout
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] o_perf_stall_cycles,
  output logic [PERF_W-1:0] o_perf_loaduse_stalls,
  output logic [PERF_W-1:0] o_perf_flushes
`endif
);

  localparam int unsigned CNT_W = $clog2(WDT_MAX + 1);

  sb_entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             timeout_q, timeout_d;
  logic             is_bj;
  logic             stall_a, stall_b, hz_stall;

`ifdef HAZARD_CTRL_PERF_EN
  logic loaduse_a, loaduse_b;
`endif

  assign is_bj = i_id_is_branch | i_id_is_jump;

  hazard_match u_match_a (
    .i_src     (i_id_rs1),
    .i_use     (i_id_use_rs1),
    .i_is_bj   (is_bj),
    .i_ex      (ex_q),
    .i_mem     (mem_q),
    .i_wb      (wb_q),
    .o_fwd_sel (o_forward_a_sel),
    .o_stall   (stall_a)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .o_loaduse (loaduse_a)
`endif
  );

  hazard_match u_match_b (
    .i_src     (i_id_rs2),
    .i_use     (i_id_use_rs2),
    .i_is_bj   (is_bj),
    .i_ex      (ex_q),
    .i_mem     (mem_q),
    .i_wb      (wb_q),
    .o_fwd_sel (o_forward_b_sel),
    .o_stall   (stall_b)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .o_loaduse (loaduse_b)
`endif
  );

  assign hz_stall = stall_a | stall_b;

  // Zero-latency pipeline controls; a memory stall freezes everything and masks flushes.
  always_comb begin
    o_stall_if      = i_mem_stall | (i_id_valid & hz_stall);
    o_stall_id      = o_stall_if;
    o_flush_id_ex   = ~i_mem_stall & i_id_valid & hz_stall;
    o_flush_if_id   = ~i_mem_stall & ~hz_stall & i_redirect_valid;
    o_stall_timeout = timeout_q;
  end

  // Scoreboard advance: hold on memory stall, inject a bubble on hazard stall.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!i_mem_stall) begin
      mem_d = ex_q;
      wb_d  = mem_q;
      if (hz_stall & i_id_valid) begin
        ex_d = '0;
      end else begin
        ex_d = '{vld: i_id_valid, rd: i_id_rd, wb: i_id_wb_en, ld: i_id_mem_read};
      end
    end
  end

  // Watchdog: saturating run length of stalled cycles and a sticky timeout flag.
  always_comb begin
    wdt_cnt_d = '0;
    if (o_stall_id) begin
      wdt_cnt_d = (wdt_cnt_q == CNT_W'(WDT_MAX)) ? wdt_cnt_q : wdt_cnt_q + CNT_W'(1);
    end
    timeout_d = timeout_q | (wdt_cnt_q == CNT_W'(WDT_MAX));
  end

  // State registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      wdt_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      wdt_cnt_q <= wdt_cnt_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
  logic [PERF_W-1:0] perf_lu_q, perf_lu_d;
  logic [PERF_W-1:0] perf_fl_q, perf_fl_d;

  // Wrapping event counters; load-use counts inserted bubbles caused by a load in EX.
  always_comb begin
    perf_stall_d = perf_stall_q + PERF_W'(o_stall_id);
    perf_lu_d    = perf_lu_q + PERF_W'((loaduse_a | loaduse_b) & i_id_valid & ~i_mem_stall);
    perf_fl_d    = perf_fl_q + PERF_W'(o_flush_if_id);
  end

  // Performance counter registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      perf_stall_q <= '0;
      perf_lu_q    <= '0;
      perf_fl_q    <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_lu_q    <= perf_lu_d;
      perf_fl_q    <= perf_fl_d;
    end
  end

  assign o_perf_stall_cycles   = perf_stall_q;
  assign o_perf_loaduse_stalls = perf_lu_q;
  assign o_perf_flushes        = perf_fl_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_id_valid;
  logic [4:0] i_id_rs1, i_id_rs2, i_id_rd;
  logic       i_id_use_rs1, i_id_use_rs2, i_id_is_branch, i_id_is_jump;
  logic       i_id_wb_en, i_id_mem_read, i_redirect_valid, i_mem_stall;
  logic [1:0] o_forward_a_sel, o_forward_b_sel;
  logic       o_stall_if, o_stall_id, o_flush_if_id, o_flush_id_ex, o_stall_timeout;

  always #5 clk = ~clk;

  hazard_ctrl #(.WDT_MAX(15)) dut (
    .i_clk            (clk),
    .i_reset          (i_reset),
    .i_id_valid       (i_id_valid),
    .i_id_rs1         (i_id_rs1),
    .i_id_rs2         (i_id_rs2),
    .i_id_rd          (i_id_rd),
    .i_id_use_rs1     (i_id_use_rs1),
    .i_id_use_rs2     (i_id_use_rs2),
    .i_id_is_branch   (i_id_is_branch),
    .i_id_is_jump     (i_id_is_jump),
    .i_id_wb_en       (i_id_wb_en),
    .i_id_mem_read    (i_id_mem_read),
    .i_redirect_valid (i_redirect_valid),
    .i_mem_stall      (i_mem_stall),
    .o_forward_a_sel  (o_forward_a_sel),
    .o_forward_b_sel  (o_forward_b_sel),
    .o_stall_if       (o_stall_if),
    .o_stall_id       (o_stall_id),
    .o_flush_if_id    (o_flush_if_id),
    .o_flush_id_ex    (o_flush_id_ex),
    .o_stall_timeout  (o_stall_timeout)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, br, jp, wb, ld, rdr, ms;
    logic [1:0] efa, efb;
    logic       est, efif, efex;
  } vec_t;

  typedef struct {
    logic [1:0] fa, fb;
    logic       st, fif, fex;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mkv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic u1, input logic u2,
                               input logic br, input logic jp, input logic wb, input logic ld,
                               input logic rdr, input logic [1:0] efa, input logic [1:0] efb,
                               input logic est, input logic efif, input logic efex);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
    t.u1 = u1; t.u2 = u2; t.br = br; t.jp = jp; t.wb = wb; t.ld = ld;
    t.rdr = rdr; t.ms = 1'b0;
    t.efa = efa; t.efb = efb; t.est = est; t.efif = efif; t.efex = efex;
    return t;
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0h expected %0h", nm, id, act, exp);
  endtask

  // Apply one ID-stage vector at the falling edge and queue its expected outputs.
  task automatic drive(input vec_t t, input int id);
    exp_t e;
    @(negedge clk);
    i_id_valid = t.v; i_id_rs1 = t.rs1; i_id_rs2 = t.rs2; i_id_rd = t.rd;
    i_id_use_rs1 = t.u1; i_id_use_rs2 = t.u2; i_id_is_branch = t.br; i_id_is_jump = t.jp;
    i_id_wb_en = t.wb; i_id_mem_read = t.ld; i_redirect_valid = t.rdr; i_mem_stall = t.ms;
    e.fa = t.efa; e.fb = t.efb; e.st = t.est; e.fif = t.efif; e.fex = t.efex; e.id = id;
    exp_q.push_back(e);
  endtask

  // Sample settled outputs before the next rising edge and compare against the queue head.
  task automatic sample();
    exp_t e;
    #3;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard: queue empty, nothing expected");
    end else begin
      e = exp_q.pop_front();
      chk("fwd_a",    e.id, 32'(o_forward_a_sel), 32'(e.fa));
      chk("fwd_b",    e.id, 32'(o_forward_b_sel), 32'(e.fb));
      chk("stall_if", e.id, 32'(o_stall_if),      32'(e.st));
      chk("stall_id", e.id, 32'(o_stall_id),      32'(e.st));
      chk("flush_if", e.id, 32'(o_flush_if_id),   32'(e.fif));
      chk("flush_ex", e.id, 32'(o_flush_id_ex),   32'(e.fex));
    end
  endtask

  vec_t vt[19];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t t;
    // ADD x5 -> BEQ x5,x0 (1 stall, then EX/MEM forward)
    vt[0]  = mkv(0, 0, 0, 0,  0,0,0,0,0,0,0, 2'b00,2'b00, 0,0,0);
    vt[1]  = mkv(1, 1, 2, 5,  1,1,0,0,1,0,0, 2'b00,2'b00, 0,0,0);
    vt[2]  = mkv(1, 5, 0, 0,  1,1,1,0,0,0,0, 2'b00,2'b00, 1,0,1);
    vt[3]  = mkv(1, 5, 0, 0,  1,1,1,0,0,0,0, 2'b10,2'b00, 0,0,0);
    // LW x6 -> ADD x7,x6,x1 (1 stall, MEM load selects RF) -> SUB x8,x1,x6 (WB forward)
    vt[4]  = mkv(1, 1, 0, 6,  1,0,0,0,1,1,0, 2'b00,2'b00, 0,0,0);
    vt[5]  = mkv(1, 6, 1, 7,  1,1,0,0,1,0,0, 2'b00,2'b00, 1,0,1);
    vt[6]  = mkv(1, 6, 1, 7,  1,1,0,0,1,0,0, 2'b00,2'b00, 0,0,0);
    vt[7]  = mkv(1, 1, 6, 8,  1,1,0,0,1,0,0, 2'b00,2'b01, 0,0,0);
    // LW x6 -> BNE x6,x2 (2 stalls, then WB forward)
    vt[8]  = mkv(1, 1, 0, 6,  1,0,0,0,1,1,0, 2'b00,2'b00, 0,0,0);
    vt[9]  = mkv(1, 6, 2, 0,  1,1,1,0,0,0,0, 2'b00,2'b00, 1,0,1);
    vt[10] = mkv(1, 6, 2, 0,  1,1,1,0,0,0,0, 2'b00,2'b00, 1,0,1);
    vt[11] = mkv(1, 6, 2, 0,  1,1,1,0,0,0,0, 2'b01,2'b00, 0,0,0);
    // JAL x1 redirect (flush) -> JALR x0,x1 redirect under hazard (no flush) -> resolves
    vt[12] = mkv(1, 0, 0, 1,  0,0,0,1,1,0,1, 2'b00,2'b00, 0,1,0);
    vt[13] = mkv(1, 1, 0, 0,  1,0,0,1,0,0,1, 2'b00,2'b00, 1,0,1);
    vt[14] = mkv(1, 1, 0, 0,  1,0,0,1,0,0,1, 2'b10,2'b00, 0,1,0);
    // ADD x0 -> BEQ x0,x0: x0 never matches
    vt[15] = mkv(1, 3, 4, 0,  1,1,0,0,1,0,0, 2'b00,2'b00, 0,0,0);
    vt[16] = mkv(1, 0, 0, 0,  1,1,1,0,0,0,0, 2'b00,2'b00, 0,0,0);
    vt[17] = mkv(0, 0, 0, 0,  0,0,0,0,0,0,0, 2'b00,2'b00, 0,0,0);
    vt[18] = mkv(0, 0, 0, 0,  0,0,0,0,0,0,0, 2'b00,2'b00, 0,0,0);

    i_reset = 1'b1;
    i_id_valid = 1'b0; i_id_rs1 = '0; i_id_rs2 = '0; i_id_rd = '0;
    i_id_use_rs1 = 1'b0; i_id_use_rs2 = 1'b0; i_id_is_branch = 1'b0; i_id_is_jump = 1'b0;
    i_id_wb_en = 1'b0; i_id_mem_read = 1'b0; i_redirect_valid = 1'b0; i_mem_stall = 1'b0;

    // Reset state
    #7;
    chk("rst_stall",   0, 32'(o_stall_id),      32'd0);
    chk("rst_fwd_a",   0, 32'(o_forward_a_sel), 32'd0);
    chk("rst_flush",   0, 32'(o_flush_id_ex),   32'd0);
    chk("rst_timeout", 0, 32'(o_stall_timeout), 32'd0);
    @(negedge clk);
    i_reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(vt[i], i);
      sample();
    end

    // Memory stall holds the scoreboard: LW x9 in EX survives 3 frozen cycles.
    t = mkv(1, 3, 0, 9, 1,0,0,0,1,1,0, 2'b00,2'b00, 0,0,0);
    drive(t, 100); sample();
    t = mkv(1, 9, 0, 10, 1,0,0,0,1,0,1, 2'b00,2'b00, 1,0,0);
    t.ms = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(t, 101 + k); sample();
    end
    t.ms = 1'b0; t.rdr = 1'b0; t.efex = 1'b1;
    drive(t, 104); sample();
    t.est = 1'b0; t.efex = 1'b0;
    drive(t, 105); sample();

    // Watchdog: 16 consecutive stall cycles set the sticky flag.
    t = mkv(0, 0, 0, 0, 0,0,0,0,0,0,0, 2'b00,2'b00, 1,0,0);
    t.ms = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      drive(t, 200 + k); sample();
      if (k == 10) chk("timeout_early", k, 32'(o_stall_timeout), 32'd0);
    end
    t.ms = 1'b0; t.est = 1'b0;
    drive(t, 300); sample();
    chk("timeout_set", 300, 32'(o_stall_timeout), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(t, 301 + k); sample();
    end
    chk("timeout_sticky", 303, 32'(o_stall_timeout), 32'd1);

    // Reset in the middle of a load-use stall drops everything at once.
    t = mkv(1, 3, 0, 11, 1,0,0,0,1,1,0, 2'b00,2'b00, 0,0,0);
    drive(t, 400); sample();
    t = mkv(1, 11, 0, 12, 1,0,0,0,1,0,0, 2'b00,2'b00, 1,0,1);
    drive(t, 401); sample();
    i_reset = 1'b1;
    #1;
    chk("rst_mid_stall_if", 402, 32'(o_stall_if),      32'd0);
    chk("rst_mid_stall_id", 402, 32'(o_stall_id),      32'd0);
    chk("rst_mid_flush_ex", 402, 32'(o_flush_id_ex),   32'd0);
    chk("rst_mid_flush_if", 402, 32'(o_flush_if_id),   32'd0);
    chk("rst_mid_fwd_a",    402, 32'(o_forward_a_sel), 32'd0);
    chk("rst_mid_timeout",  402, 32'(o_stall_timeout), 32'd0);
    @(negedge clk);
    i_reset = 1'b0;
    i_id_valid = 1'b0;
    #3;
    chk("post_rst_timeout", 403, 32'(o_stall_timeout), 32'd0);
    chk("post_rst_stall",   403, 32'(o_stall_id),      32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
